// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Purpose  : Instruction fetch/phase sequencer for the Georgios CPU.       |
// |            Optional fetch watchdog enabled by FETCH_SEQ_TIMEOUT_EN.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter int W             = 8,
    parameter int OP_W          = 3,
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic [W-1:0]     imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [W-1:0]     imem_data,
    output logic [W-1:0]     instr,
    output logic [OP_W-1:0]  op,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic [W-1:0]     pc,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [OP_W-1:0] c_OP_HALT = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_NOP  = OP_W'(1);

    if (FETCH_TIMEOUT < 1) begin : g_bad_timeout
        $error("FETCH_TIMEOUT must be at least 1");
    end

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [W-1:0]     r_pc;
    logic [W-1:0]     r_instr;
    logic [CNT_W-1:0] r_retired;
    logic [OP_W-1:0]  w_op_in;
    logic             w_fetch_ack;
    logic             w_retire;
    logic             w_timeout;

    assign w_op_in     = imem_data[W-1:W-OP_W];
    assign w_fetch_ack = (r_state == S_FETCH) && imem_ack;
    // A nop retires on its own ack; everything else retires leaving WRITE.
    assign w_retire    = (w_fetch_ack && (w_op_in == c_OP_NOP)) || (r_state == S_WRITE);

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(FETCH_TIMEOUT - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Counts ack-less FETCH cycles; any other cycle (or an ack) restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_FETCH) && !imem_ack) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_FETCH) && !imem_ack && (r_to_cnt == c_TO_LAST);
    assign error     = (r_state == S_ERROR);
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    if (w_op_in == c_OP_HALT)     w_next = S_HALT;
                    else if (w_op_in == c_OP_NOP) w_next = run ? S_FETCH : S_IDLE;
                    else                          w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = S_WRITE;
            S_WRITE:  w_next = run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_fetch_ack) begin
                r_instr <= imem_data;
            end
            if (w_retire) begin
                r_pc      <= r_pc + 1'b1;
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = (r_state == S_FETCH);
    assign instr     = r_instr;
    assign op        = r_instr[W-1:W-OP_W];
    assign decode_en = (r_state == S_DECODE);
    assign exec_en   = (r_state == S_EXEC);
    assign wb_en     = (r_state == S_WRITE);
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign retired   = r_retired;

endmodule
`default_nettype wire
